// File: rtl/bus_mux_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_mux_arb                                               |
// | Brief    : N-channel registered bus multiplexer with arbitration and |
// |            a valid/ready output register. Define BUS_MUX_ARB_RR_EN   |
// |            for round-robin arbitration; default is fixed priority.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bus_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*WIDTH-1:0]   din,
  output logic [NCH-1:0]         grant,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(NCH)-1:0] sel_out
);

  localparam int SELW = $clog2(NCH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  win_idx;
  logic [WIDTH-1:0] win_data;
  logic             cap;

`ifdef BUS_MUX_ARB_RR_EN
  logic [SELW-1:0]  ptr_q, ptr_d;
`endif

  // Descending scan so the last assignment is the first candidate in search order.
  always_comb begin : p_arb
`ifdef BUS_MUX_ARB_RR_EN
    int cand;
    win_idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NCH) cand = cand - NCH;
      if (req[cand]) win_idx = SELW'(cand);
    end
`else
    win_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) win_idx = SELW'(i);
    end
`endif
  end

  assign win_data = din[win_idx*WIDTH +: WIDTH];
  assign cap      = (|req) & ((state_q == S_IDLE) | dout_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      sel_q   <= '0;
`ifdef BUS_MUX_ARB_RR_EN
      ptr_q   <= SELW'(NCH - 1);
`endif
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
`ifdef BUS_MUX_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // A capture in HOLD consumes the current word and loads the next on the same edge.
  always_comb begin : p_next
    state_d = state_q;
    dout_d  = dout_q;
    sel_d   = sel_q;
`ifdef BUS_MUX_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    if (cap) begin
      state_d = S_HOLD;
      dout_d  = win_data;
      sel_d   = win_idx;
`ifdef BUS_MUX_ARB_RR_EN
      ptr_d   = win_idx;
`endif
    end else if ((state_q == S_HOLD) && dout_ready) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin : p_out
    grant      = '0;
    if (cap && !reset) grant[win_idx] = 1'b1;
    dout       = dout_q;
    sel_out    = sel_q;
    dout_valid = (state_q == S_HOLD);
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_mux_arb.sv
`default_nettype none
// Scoreboard bench for bus_mux_arb: a queue-based arbitration model predicts
// every captured word and the combinational grant; a negedge monitor checks.
module tb_bus_mux_arb;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] din;
  logic [NCH-1:0]       grant;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [SELW-1:0]      sel_out;

  logic                 reset2;
  logic [7:0]           req2;
  logic [8*16-1:0]      din2;
  logic [7:0]           grant2;
  logic [15:0]          dout2;
  logic                 dout_valid2;
  logic                 dout_ready2;
  logic [2:0]           sel_out2;

  always #5 clk = ~clk;

  bus_mux_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .grant(grant),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .sel_out(sel_out)
  );

  bus_mux_arb #(.WIDTH(16), .NCH(8)) dut_wide (
    .clk(clk), .reset(reset2), .req(req2), .din(din2), .grant(grant2),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready2), .sel_out(sel_out2)
  );

  typedef struct packed {
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t          exp_q[$];
  logic [NCH-1:0] exp_grant;
  logic           exp_valid;
  bit             m_valid;
  int             m_ptr;
  bit             mon_en;
  int             vectors = 0;
  int             errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is captured whenever someone requests and the output
  // slot is empty or being emptied; the winner comes from the arbitration rule.
  task automatic model_eval();
    int    win;
    bit    take;
    word_t w;
    exp_valid = m_valid;
    take      = (req != '0) && (!m_valid || dout_ready);
    win       = -1;
`ifdef BUS_MUX_ARB_RR_EN
    for (int k = 1; k <= NCH; k++)
      if (win < 0 && req[(m_ptr + k) % NCH]) win = (m_ptr + k) % NCH;
`else
    for (int i = 0; i < NCH; i++)
      if (win < 0 && req[i]) win = i;
`endif
    exp_grant = '0;
    if (take) begin
      exp_grant[win] = 1'b1;
      w.sel  = SELW'(win);
      w.data = din[win*WIDTH +: WIDTH];
      exp_q.push_back(w);
      m_valid = 1'b1;
      m_ptr   = win;
    end else if (dout_ready) begin
      m_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    word_t w;
    if (mon_en && !reset) begin
      check("grant", 32'(grant), 32'(exp_grant));
      check("dout_valid", 32'(dout_valid), 32'(exp_valid));
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_word: got dout=%0h sel=%0d, none expected", dout, sel_out);
        end else begin
          w = exp_q.pop_front();
          check("dout", 32'(dout), 32'(w.data));
          check("sel_out", 32'(sel_out), 32'(w.sel));
        end
      end
    end
  end

  task automatic step(input logic [NCH-1:0] r, input logic rdy, input logic [NCH*WIDTH-1:0] d);
    @(posedge clk);
    #1;
    req        = r;
    dout_ready = rdy;
    din        = d;
    model_eval();
  endtask

  function automatic logic [NCH*WIDTH-1:0] rand_din();
    logic [NCH*WIDTH-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_valid   = 1'b0;
    m_ptr     = NCH - 1;
    exp_grant = '0;
    exp_valid = 1'b0;
  endtask

  initial begin
    logic [NCH*WIDTH-1:0] d;
    mon_en      = 1'b0;
    reset       = 1'b1;
    req         = 4'hF;
    din         = '0;
    dout_ready  = 1'b0;
    reset2      = 1'b1;
    req2        = '0;
    din2        = '0;
    dout_ready2 = 1'b0;
    model_reset();

    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_sel", 32'(sel_out), 32'h0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    model_eval();
    mon_en = 1'b1;
    #1;
    check("first_grant", 32'(grant), 32'h1);

    // Drain, then single request on channel 2 held for five cycles.
    step(4'b0000, 1'b1, rand_din());
    d = rand_din();
    d[2*WIDTH +: WIDTH] = 8'hA5;
    step(4'b0100, 1'b0, d);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b0, rand_din());
      #2;
      check("hold_dout", 32'(dout), 32'hA5);
      check("hold_sel", 32'(sel_out), 32'h2);
    end
    step(4'b0000, 1'b1, rand_din());
    step(4'b0000, 1'b0, rand_din());

    // Back-to-back streaming, then four-way fairness with a drop-out.
    repeat (6) step(4'b0011, 1'b1, rand_din());
    repeat (5) step(4'b1111, 1'b1, rand_din());
    repeat (4) step(4'b1101, 1'b1, rand_din());
    step(4'b0000, 1'b1, rand_din());

    // Withdrawn request on channel 3 while the slot is full.
    step(4'b0001, 1'b0, rand_din());
    step(4'b1000, 1'b0, rand_din());
    step(4'b0000, 1'b0, rand_din());
    step(4'b0000, 1'b1, rand_din());
    step(4'b0000, 1'b0, rand_din());

    repeat (300) step(NCH'($urandom), 1'($urandom), rand_din());

    // Asynchronous reset while a word is held.
    step(4'b0010, 1'b0, rand_din());
    step(4'b0000, 1'b0, rand_din());
    #2;
    check("pre_reset_valid", 32'(dout_valid), 32'h1);
    mon_en = 1'b0;
    reset  = 1'b1;
    req    = 4'hF;
    #1;
    check("async_valid", 32'(dout_valid), 32'h0);
    check("async_dout", 32'(dout), 32'h0);
    check("async_sel", 32'(sel_out), 32'h0);
    check("async_grant", 32'(grant), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_eval();
    mon_en = 1'b1;

    repeat (100) step(NCH'($urandom), 1'($urandom), rand_din());
    repeat (3) step(4'b0000, 1'b1, rand_din());
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;

    // Wide configuration: 16-bit data, 8 channels, highest channel only.
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    din2   = {16'hBEEF, 112'h0};
    req2   = 8'h80;
    #1;
    check("wide_grant", 32'(grant2), 32'h80);
    @(posedge clk);
    #1;
    req2 = 8'h00;
    check("wide_dout", 32'(dout2), 32'hBEEF);
    check("wide_sel", 32'(sel_out2), 32'h7);
    check("wide_valid", 32'(dout_valid2), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
